// File: rtl/sha256_pkg.sv
// Shared types, constants and helpers for the streaming SHA-256 engine and its round core.
package sha256_pkg;

  typedef enum logic [2:0] {StIdle, StRun, StPad, StDbl, StDone} state_t;

  // Byte i of a block holds message byte 4*(i/4)+3-(i%4), so 32-bit word w is big-endian word w.
  typedef logic [63:0][7:0] block_t;
  typedef logic [7:0][31:0] digest_t;

  localparam digest_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                            32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Keeps message bytes below len, optionally marks the 0x80 terminator at byte len and puts
  // the big-endian bit length in message bytes 56..63.
  function automatic block_t pad_block(input block_t data, input logic [6:0] len,
                                       input logic put80, input logic put_len,
                                       input logic [63:0] bitlen);
    block_t     blk;
    logic [5:0] p;
    for (int b = 0; b < 64; b++) begin
      p = {b[5:2], ~b[1:0]};
      blk[p] = (b < int'(len)) ? data[p] : 8'h00;
      if (put80 && b == int'(len)) blk[p] = 8'h80;
      if (put_len && b >= 56) blk[p] = 8'(bitlen >> (8 * (63 - b)));
    end
    return blk;
  endfunction

endpackage

// File: rtl/tumble.sv
// Iterative SHA-256 compression core: one round per clock, block and chaining state latched on
// in_valid, one-cycle out_valid pulse with the updated chaining state.
module tumble
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  block_t      in_data,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  input  logic [31:0] state4,
  input  logic [31:0] state5,
  input  logic [31:0] state6,
  input  logic [31:0] state7,
  output logic        out_valid,
  output digest_t     out_res
);

  logic [15:0][31:0] w_q;
  digest_t           v_q, h_q, v_d, sum;
  logic [5:0]        rnd_q;
  logic              busy_q, out_valid_q;
  digest_t           out_res_q;
  logic [31:0]       t1, t2, w_new;

  // v_q[0..7] are the working variables a..h; w_q[0] is the schedule word for this round.
  always_comb begin
    t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + w_q[0];
    t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    v_d = {v_q[6:4], v_q[3] + t1, v_q[2:0], t1 + t2};
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    for (int k = 0; k < 8; k++) sum[k] = h_q[k] + v_d[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      v_q         <= '0;
      h_q         <= '0;
      rnd_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid && !busy_q) begin
        w_q    <= in_data;
        h_q    <= {state7, state6, state5, state4, state3, state2, state1, state0};
        v_q    <= {state7, state6, state5, state4, state3, state2, state1, state0};
        rnd_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        v_q   <= v_d;
        w_q   <= {w_new, w_q[15:1]};
        rnd_q <= rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          out_res_q   <= sum;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;

endmodule

// File: rtl/sha256_stream.sv
// Multi-block SHA-256 controller: pads a chunked message, chains blocks through the round core
// and optionally rehashes the 32-byte digest.
module sha256_stream
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W  = 32,
  parameter bit          DBL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0][7:0] in_data,
  input  logic [6:0]       in_len,
  input  logic             in_last,
  input  logic             in_dbl,
  output logic             out_valid,
  output logic [31:0][7:0] out_res,
  output logic             out_err
);

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q, cnt_sum;
  digest_t          chain_q, out_res_q, core_res;
  block_t           blk_q, blk_first, blk_pad, blk_dbl;
  logic [6:0]       len_q;
  logic             core_valid_q, issued_q, last_q, dbl_q, first_q;
  logic             in_ready_q, out_valid_q, out_err_q;
  logic             core_out_valid, core_done, len_bad;
  logic [63:0]      bitlen_in, bitlen_q;

  always_comb begin
    cnt_sum   = cnt_q + LEN_W'(in_len);
    bitlen_in = 64'({cnt_sum, 3'b000});
    bitlen_q  = 64'({cnt_q, 3'b000});
    len_bad   = (in_len > 7'd64) || (!in_last && in_len != 7'd64);
    blk_first = pad_block(in_data, in_len, in_last && (in_len < 7'd64),
                          in_last && (in_len <= 7'd55), bitlen_in);
    // 0x80 only lands here when the final chunk was full; for 56..63 it is already placed.
    blk_pad   = pad_block('0, 7'd0, len_q == 7'd64, 1'b1, bitlen_q);
    blk_dbl   = pad_block(block_t'({256'b0, chain_q}), 7'd32, 1'b1, 1'b1, 64'd256);
    // The issue cycle itself never counts as completion.
    core_done = core_out_valid && !core_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      chain_q      <= IV;
      blk_q        <= '0;
      len_q        <= '0;
      core_valid_q <= 1'b0;
      issued_q     <= 1'b0;
      last_q       <= 1'b0;
      dbl_q        <= 1'b0;
      first_q      <= 1'b1;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_res_q    <= '0;
    end else begin
      core_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            if (len_bad) begin
              out_err_q <= 1'b1;
              cnt_q     <= '0;
              chain_q   <= IV;
              first_q   <= 1'b1;
            end else begin
              if (first_q) dbl_q <= DBL_EN && in_dbl;
              first_q      <= 1'b0;
              cnt_q        <= cnt_sum;
              blk_q        <= blk_first;
              len_q        <= in_len;
              last_q       <= in_last;
              core_valid_q <= 1'b1;
              in_ready_q   <= 1'b0;
              state_q      <= StRun;
            end
          end
        end
        StRun: begin
          if (core_done) begin
            chain_q <= core_res;
            if (!last_q) begin
              in_ready_q <= 1'b1;
              state_q    <= StIdle;
            end else if (len_q >= 7'd56) begin
              state_q <= StPad;
            end else begin
              state_q <= dbl_q ? StDbl : StDone;
            end
          end
        end
        StPad: begin
          if (!issued_q) begin
            blk_q        <= blk_pad;
            core_valid_q <= 1'b1;
            issued_q     <= 1'b1;
          end else if (core_done) begin
            chain_q  <= core_res;
            issued_q <= 1'b0;
            state_q  <= dbl_q ? StDbl : StDone;
          end
        end
        StDbl: begin
          if (!issued_q) begin
            blk_q        <= blk_dbl;
            chain_q      <= IV;
            core_valid_q <= 1'b1;
            issued_q     <= 1'b1;
          end else if (core_done) begin
            chain_q  <= core_res;
            issued_q <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          out_res_q   <= chain_q;
          out_valid_q <= 1'b1;
          chain_q     <= IV;
          cnt_q       <= '0;
          first_q     <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  tumble u_core (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (core_valid_q),
    .in_data   (blk_q),
    .state0    (chain_q[0]),
    .state1    (chain_q[1]),
    .state2    (chain_q[2]),
    .state3    (chain_q[3]),
    .state4    (chain_q[4]),
    .state5    (chain_q[5]),
    .state6    (chain_q[6]),
    .state7    (chain_q[7]),
    .out_valid (core_out_valid),
    .out_res   (core_res)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_err   = out_err_q;

endmodule
